// File: rtl/addsub4_pkg.sv
// Shared constants and helpers for the addsub4 issuer/collector slice.
package addsub4_pkg;

    localparam int   CORE_LAT_DEF = 2;
    localparam logic OP_ADD       = 1'b0;
    localparam logic OP_SUB       = 1'b1;
    localparam int   Y_W          = 4;
    localparam int   FLAG_W       = 2;

    function automatic int popcount32(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/addsub4_rsp_fifo.sv
// Synchronous DEPTH-entry FIFO; head is read combinationally from registered storage.
module addsub4_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    addsub4_rsp_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .count (count_q)
    );

endmodule

// File: rtl/addsub4_rsp_fifo_chk.sv
// Property checker for the response FIFO: a push must never land on a full FIFO.
module addsub4_rsp_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [CW-1:0] count
);

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && (count == CW'(DEPTH)))
    );

endmodule

// File: rtl/addsub4_issuer.sv
// Issues tagged requests into the fixed-latency addsub4 core and collects results
// into a credit-protected response FIFO.
module addsub4_issuer
    import addsub4_pkg::*;
#(
    parameter int TAG_W    = 2,
    parameter int DEPTH    = 4,
    parameter int CORE_LAT = CORE_LAT_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    input  logic             req_sub,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       core_a,
    output logic [3:0]       core_b,
    output logic             core_sub,
    input  logic [3:0]       core_y,
    input  logic             core_cout,
    input  logic             core_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_y,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = Y_W + FLAG_W + TAG_W;

    logic [CORE_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]    pipe_tag_q [CORE_LAT];
    logic [TAG_W-1:0]    pipe_tag_d [CORE_LAT];
    logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic [CW-1:0]       fifo_count_s;
    logic [CW-1:0]       inflight_s;
    logic [CW:0]         credit_used_s;
    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [RW-1:0]       push_data_s;
    logic [RW-1:0]       head_s;

    assign core_a   = req_a;
    assign core_b   = req_b;
    assign core_sub = req_sub;

    // Credits count both queued and still-in-core results, from registered state only.
    assign inflight_s    = CW'(popcount32(32'(pipe_vld_q)));
    assign credit_used_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
    assign req_ready     = credit_used_s < (CW+1)'(DEPTH);
    assign accept_s      = req_valid & req_ready;

    assign push_s      = pipe_vld_q[CORE_LAT-1];
    assign push_data_s = {core_y, core_cout, core_ovf, pipe_tag_q[CORE_LAT-1]};
    assign rsp_valid   = fifo_count_s != CW'(0);
    assign pop_s       = rsp_valid & rsp_ready;
    assign {rsp_y, rsp_cout, rsp_ovf, rsp_tag} = head_s;
    assign ovf_count   = ovf_cnt_q;

    // Valid/tag shift pipe mirroring the core latency, plus the saturating overflow count.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_tag_d    = pipe_tag_q;
        ovf_cnt_d     = ovf_cnt_q;
        pipe_vld_d[0] = accept_s;
        if (accept_s) begin
            pipe_tag_d[0] = req_tag;
        end else begin
            pipe_tag_d[0] = TAG_W'(0);
        end
        for (int i = 1; i < CORE_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        if (pop_s && rsp_ovf && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

    // Pipe and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                pipe_tag_q[i] <= '0;
            end
            ovf_cnt_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    addsub4_rsp_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_addsub4_issuer.sv
// Self-checking bench for addsub4_issuer with a behavioural 2-stage addsub4 core.
module tb_addsub4_issuer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_a = 4'd0;
    logic [3:0] req_b = 4'd0;
    logic       req_sub = 1'b0;
    logic [1:0] req_tag = 2'd0;
    logic [3:0] core_a, core_b;
    logic       core_sub;
    logic [3:0] core_y;
    logic       core_cout, core_ovf;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_y;
    logic       rsp_cout, rsp_ovf;
    logic [1:0] rsp_tag;
    logic [7:0] ovf_count;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_pops = 0;
    int exp_ovf = 0;
    logic [7:0] sb_q [$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [1:0] tag;
        logic [3:0] y;
        logic       cout;
        logic       ovf;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    addsub4_issuer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_tag(req_tag),
        .core_a(core_a), .core_b(core_b), .core_sub(core_sub),
        .core_y(core_y), .core_cout(core_cout), .core_ovf(core_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_tag(rsp_tag),
        .ovf_count(ovf_count)
    );

    // Behavioural core: operands registered at one edge, result registered at the next.
    logic [3:0] s1_a, s1_b;
    logic       s1_sub;
    logic [3:0] bx_s;
    logic [4:0] sum5_s;
    always_comb begin
        bx_s   = s1_b ^ {4{s1_sub}};
        sum5_s = {1'b0, s1_a} + {1'b0, bx_s} + {4'b0000, s1_sub};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a <= 4'd0; s1_b <= 4'd0; s1_sub <= 1'b0;
            core_y <= 4'd0; core_cout <= 1'b0; core_ovf <= 1'b0;
        end else begin
            s1_a <= core_a; s1_b <= core_b; s1_sub <= core_sub;
            core_y    <= sum5_s[3:0];
            core_cout <= sum5_s[4];
            core_ovf  <= (s1_a[3] == bx_s[3]) && (sum5_s[3] != s1_a[3]);
        end
    end

    // Reference arithmetic in plain integers: returns {y, cout, ovf}.
    function automatic logic [5:0] ref_calc(input logic [3:0] a, input logic [3:0] b, input logic sub);
        int ua, ub, sa, sbv, r, s;
        logic c, o;
        logic [3:0] y;
        ua = int'(a);
        ub = int'(b);
        sa  = (ua >= 8) ? ua - 16 : ua;
        sbv = (ub >= 8) ? ub - 16 : ub;
        if (sub) begin
            r = ua - ub; c = (ua >= ub); s = sa - sbv;
        end else begin
            r = ua + ub; c = (r > 15); s = sa + sbv;
        end
        y = r[3:0];
        o = (s > 7) || (s < -8);
        return {y, c, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_rand(input logic [1:0] tag);
        req_valid = 1'b1;
        req_a   = 4'($urandom_range(0, 15));
        req_b   = 4'($urandom_range(0, 15));
        req_sub = 1'($urandom_range(0, 1));
        req_tag = tag;
    endtask

    // Scoreboard: handshakes that will fire at the next rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        if (!rst_n) begin
            sb_q.delete();
            exp_ovf = 0;
        end else begin
            if (req_valid && req_ready) begin
                sb_q.push_back({ref_calc(req_a, req_b, req_sub), req_tag});
                n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                n_pops++;
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_tag), 32'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_rsp", 32'({rsp_y, rsp_cout, rsp_ovf, rsp_tag}), 32'(e));
                    check("sb_ovf_count", 32'(ovf_count), 32'(exp_ovf));
                    if (e[2]) exp_ovf++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, acc, a0, p0;
        logic [15:0] hist;

        tbl[0] = '{4'd5,  4'd3, 1'b0, 2'd1, 4'd8,  1'b0, 1'b1};
        tbl[1] = '{4'd3,  4'd5, 1'b1, 2'd2, 4'd14, 1'b0, 1'b0};
        tbl[2] = '{4'd7,  4'd8, 1'b1, 2'd3, 4'd15, 1'b0, 1'b1};
        tbl[3] = '{4'd15, 4'd1, 1'b0, 2'd0, 4'd0,  1'b1, 1'b0};
        tbl[4] = '{4'd8,  4'd8, 1'b0, 2'd1, 4'd0,  1'b1, 1'b1};
        tbl[5] = '{4'd5,  4'd5, 1'b1, 2'd2, 4'd0,  1'b1, 1'b0};
        tbl[6] = '{4'd8,  4'd1, 1'b1, 2'd3, 4'd7,  1'b1, 1'b1};
        tbl[7] = '{4'd0,  4'd0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0};
        tbl[8] = '{4'd9,  4'd3, 1'b0, 2'd1, 4'd12, 1'b0, 1'b0};
        tbl[9] = '{4'd0,  4'd8, 1'b1, 2'd2, 4'd8,  1'b0, 1'b1};

        // Reset state
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", 32'({rsp_y, rsp_cout, rsp_ovf, rsp_tag}), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        cyc(); cyc();
        rst_n = 1'b1;

        // Single requests from the table: latency and result fields
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            req_valid = 1'b1; req_a = tbl[i].a; req_b = tbl[i].b;
            req_sub = tbl[i].sub; req_tag = tbl[i].tag;
            #1 check("tbl_ready", 32'(req_ready), 32'd1);
            @(posedge clk); edges = 1;
            cyc(); req_valid = 1'b0; #1;
            while (!rsp_valid && edges < 10) begin
                @(posedge clk); edges++;
                @(negedge clk); #1;
            end
            check("tbl_latency", 32'(edges), 32'd3);
            check("tbl_rsp", 32'({rsp_y, rsp_cout, rsp_ovf, rsp_tag}),
                  32'({tbl[i].y, tbl[i].cout, tbl[i].ovf, tbl[i].tag}));
        end

        // Back-to-back: 8 requests on consecutive cycles, 8 responses on consecutive cycles
        hist = 16'd0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (c < 8) drive_rand(2'(c)); else req_valid = 1'b0;
            #1;
            if (c < 8) check("b2b_ready", 32'(req_ready), 32'd1);
            hist[c] = rsp_valid;
        end
        check("b2b_rsp_window", 32'(hist), 32'h07F8);

        // Backpressure: exactly DEPTH accepts, then drain in order
        rsp_ready = 1'b0; acc = 0; a0 = n_acc; p0 = n_pops;
        for (int c = 0; c < 8; c++) begin
            cyc(); drive_rand(2'(c));
            #1 if (req_ready) acc++;
        end
        check("bp_accepts", 32'(acc), 32'd4);
        cyc(); req_valid = 1'b0;
        #1 check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
            cyc(); #3;
        end
        cyc(); #1;
        check("bp_drained", 32'(sb_q.size()), 32'd0);
        check("bp_ready_back", 32'(req_ready), 32'd1);
        check("bp_rsp_empty", 32'(rsp_valid), 32'd0);
        check("bp_pop_eq_acc", 32'(n_pops - p0), 32'(n_acc - a0));

        // Full FIFO with simultaneous pop and new accepts
        rsp_ready = 1'b0; a0 = n_acc; p0 = n_pops;
        for (int c = 0; c < 6; c++) begin
            cyc();
            req_valid = 1'b1; req_a = 4'd7; req_b = 4'(c); req_sub = 1'b0; req_tag = 2'(c);
        end
        cyc(); req_valid = 1'b0;
        cyc(); cyc(); cyc();
        #1 check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        check("full_ready_low", 32'(req_ready), 32'd0);
        cyc(); rsp_ready = 1'b1; drive_rand(2'd0);
        #1 check("full_first_ready", 32'(req_ready), 32'd0);
        cyc(); drive_rand(2'd1);
        #1 check("full_after_pop_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 10; c++) begin
            cyc(); drive_rand(2'(c));
        end
        cyc(); req_valid = 1'b0;
        for (int c = 0; c < 30 && sb_q.size() != 0; c++) begin
            cyc(); #3;
        end
        cyc(); cyc(); #1;
        check("full_drained", 32'(sb_q.size()), 32'd0);
        check("full_pop_eq_acc", 32'(n_pops - p0), 32'(n_acc - a0));
        check("full_ovf_count", 32'(ovf_count), 32'(exp_ovf));
        check("full_rsp_empty", 32'(rsp_valid), 32'd0);

        // Reset with 2 queued and 2 in flight
        rsp_ready = 1'b0;
        cyc(); drive_rand(2'd1);
        cyc(); drive_rand(2'd2);
        cyc(); req_valid = 1'b0;
        cyc(); cyc(); cyc();
        cyc(); drive_rand(2'd3);
        cyc(); drive_rand(2'd0);
        cyc(); req_valid = 1'b0;
        #1 check("pre_rst_ready_low", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        cyc(); cyc();
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc(); #1 check("post_rst_no_stale", 32'(rsp_valid), 32'd0);
        end
        check("post_rst_ovf_count", 32'(ovf_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
